pe_tensor_mc: RTL
=================

Name: pe_tensor_mc

Overview:
Parametrised, multi-channel successor to the 3x3 convolution PE tensor. Holds one KSIZE x KSIZE filter per input channel. Takes a stream of ifmap windows, one channel per beat, through a pipelined MAC with a valid/ready handshake. Accumulates NUM_CH consecutive beats into one saturated output pixel. Sits between the ifmap line-buffer/window generator and the output writeback.

Parameters:
DATA_W, 8, signed ifmap/weight element width
KSIZE, 3, kernel side; window = KSIZE*KSIZE elements
NUM_CH, 4, input channels accumulated per output pixel
ACC_W, 24, internal signed accumulator width
OUT_W, 16, signed saturated output width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wb_write_en  in  1  weight write strobe
wb_addr  in  max(1,clog2(NUM_CH))  channel index of the weight write
filter_in  in  KSIZE*KSIZE*DATA_W  packed filter, element 0 in LSBs
start  in  1  pulse; IDLE -> RUN
stop  in  1  pulse; request end of stream
ifmap_valid  in  1  ifmap beat valid
ifmap_ready  out  1  ifmap beat accepted when valid && ready
ifmap  in  KSIZE*KSIZE*DATA_W  packed window for the current channel
out_valid  out  1  psum_out valid
out_ready  in  1  downstream accepts psum_out
psum_out  out  OUT_W  saturated signed result
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all weights=0; ch_cnt=0; pipeline valids=0; out_valid=0; psum_out=0; ifmap_ready=0; busy=0. Reset mid-operation discards all in-flight data.
- Weight writes are honoured only in IDLE: weights[wb_addr] <= filter_in. Writes in RUN or DRAIN are ignored. A wb_addr >= NUM_CH is ignored.
- FSM:
  - IDLE: on start, go to RUN.
  - RUN: on stop with ch_cnt==0 (window boundary), go to DRAIN. If stop arrives with ch_cnt!=0, latch stop_pend and go to DRAIN when the window's last beat is accepted. start is ignored outside IDLE.
  - DRAIN: ifmap_ready=0. Go to IDLE when all pipeline valids are 0 and out_valid==0.
- Stall: en = !(out_valid && !out_ready). All pipeline stages advance only when en=1.
- ifmap_ready = (state==RUN) && en && !stop_pend_done. A beat is accepted when ifmap_valid && ifmap_ready.
- Channel counter: ch_cnt increments per accepted beat and wraps NUM_CH-1 -> 0. Beat c uses weights[ch_cnt]. The first and last flags travel down the pipeline with the beat.
- Pipeline, with edge 0 = acceptance edge and no stalls:
  - S1 (edge 0): KSIZE*KSIZE signed products, 2*DATA_W each.
  - S2 (edge 1): adder-tree sum, sign-extended to ACC_W.
  - S3 (edge 2): acc = first ? sum : acc + sum. The accumulator wraps modulo 2^ACC_W; defaults cannot overflow.
  - OUT (edge 3): if last, psum_out = sat(acc) to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and out_valid=1.
- Latency from last-beat acceptance to out_valid is 3 cycles. Throughput is 1 beat/cycle without backpressure.
- out_valid clears on out_valid && out_ready unless a new result loads the same cycle. psum_out is held stable while out_valid && !out_ready.
- Simultaneous start+stop in IDLE: start wins, stop ignored.

Decomposition:
- Shared package pe_pkg holds: DATA_W/KSIZE/NUM_CH defaults, the derived widths KK=KSIZE*KSIZE, PROD_W=2*DATA_W, TREE_W=PROD_W+clog2(KK), and the FSM state enum (IDLE, RUN, DRAIN).
- One sub-module: pe_mac_tree (registered products plus registered adder tree, with enable), instantiated once.

Test Plan:
1. All weights=1 on ch0..3, start, 4 beats of all elements=2, out_ready=1 -> out_valid exactly 3 cycles after the 4th acceptance, psum_out=72 (18 per channel).
2. Saturation: weights=127, ifmap=127 on all channels -> psum_out=32767. Weights=-128, ifmap=127 -> psum_out=-32768.
3. Backpressure: stream 3 windows, hold out_ready=0 for 5 cycles after the first out_valid -> ifmap_ready=0 while held, psum_out stable, then all 3 results correct and in order.
4. Weight write in RUN: write ch0=5 mid-stream -> ignored; results identical to test 1. The same write in IDLE takes effect on the next run.
5. stop pulsed at ch_cnt=2 -> window completes, state goes to DRAIN, busy drops 1 cycle after the final out_valid&&out_ready, ifmap_ready stays 0 afterwards.
6. rst asserted mid-window with out_valid=1 -> out_valid, psum_out, busy go 0 immediately. Next run with unloaded weights gives psum_out=0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared defaults, derived widths and FSM state for the multi-channel PE tensor.
package pe_pkg;
    localparam int PE_DATA_W = 8;
    localparam int PE_KSIZE  = 3;
    localparam int PE_NUM_CH = 4;
    localparam int KK        = PE_KSIZE * PE_KSIZE;
    localparam int PROD_W    = 2 * PE_DATA_W;
    localparam int TREE_W    = PROD_W + $clog2(KK);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic int tree_width(input int data_w, input int kk);
        return 2 * data_w + $clog2(kk);
    endfunction
endpackage

// File: rtl/pe_mac_tree.sv
// Registered signed products feeding a registered adder tree; both stages hold when en is low.
module pe_mac_tree
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int N_EL   = KK,
    parameter int SUM_W  = TREE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_EL*DATA_W-1:0] ifmap,
    input  logic [N_EL*DATA_W-1:0] weight,
    output logic [SUM_W-1:0]       sum
);
    localparam int P_W = 2 * DATA_W;

    logic signed [P_W-1:0]   prod [N_EL];
    logic signed [SUM_W-1:0] sum_nx;

    for (genvar k = 0; k < N_EL; k++) begin : g_mul
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                prod[k] <= '0;
            else if (en)
                prod[k] <= P_W'($signed(ifmap[k*DATA_W +: DATA_W]))
                         * P_W'($signed(weight[k*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        sum_nx = '0;
        for (int k = 0; k < N_EL; k++)
            sum_nx = sum_nx + SUM_W'(prod[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     sum <= '0;
        else if (en) sum <= sum_nx;
    end
endmodule

// File: rtl/pe_tensor_mc.sv
// Multi-channel convolution PE: per-channel filters, pipelined MAC, NUM_CH-beat accumulation
// into one saturated output pixel behind a valid/ready handshake.
module pe_tensor_mc
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int KSIZE  = PE_KSIZE,
    parameter int NUM_CH = PE_NUM_CH,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wb_write_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wb_addr,
    input  logic [KSIZE*KSIZE*DATA_W-1:0]            filter_in,
    input  logic                                     start,
    input  logic                                     stop,
    input  logic                                     ifmap_valid,
    output logic                                     ifmap_ready,
    input  logic [KSIZE*KSIZE*DATA_W-1:0]            ifmap,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OUT_W-1:0]                         psum_out,
    output logic                                     busy
);
    localparam int N_EL   = KSIZE * KSIZE;
    localparam int VEC_W  = N_EL * DATA_W;
    localparam int SUM_W  = tree_width(DATA_W, N_EL);
    localparam int AW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STAGES = 3;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    state_t                       state, state_nx;
    logic [NUM_CH-1:0][VEC_W-1:0] weights;
    logic [AW-1:0]                ch_cnt;
    logic                         stop_pend, stop_req, at_bound;
    logic                         en, accept, first_beat, last_beat;
    logic [STAGES:1]              vld_pipe, last_pipe;
    logic [2:1]                   first_pipe;
    logic signed [SUM_W-1:0]      tree_sum;
    logic signed [ACC_W-1:0]      sum_ext, acc;
    logic [OUT_W-1:0]             sat_val;

    assign en          = !(out_valid && !out_ready);
    assign stop_req    = stop || stop_pend;
    // A stop seen on a window boundary must not let a new window start.
    assign at_bound    = stop_req && (ch_cnt == '0);
    assign ifmap_ready = (state == RUN) && en && !at_bound;
    assign accept      = ifmap_valid && ifmap_ready;
    assign first_beat  = (ch_cnt == '0);
    assign last_beat   = (ch_cnt == AW'(NUM_CH - 1));
    assign busy        = (state != IDLE);
    assign sum_ext     = ACC_W'(tree_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (at_bound || (accept && last_beat && stop_req)) state_nx = DRAIN;
            // Leave as the last result is taken, so busy falls the cycle after the handshake.
            DRAIN:   if (vld_pipe == '0 && (!out_valid || out_ready)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stop_pend <= 1'b0;
        else if (state_nx != RUN)
            stop_pend <= 1'b0;
        else if (state == RUN && stop && ch_cnt != '0)
            stop_pend <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            weights <= '0;
        else if (state == IDLE && wb_write_en && 32'(wb_addr) < NUM_CH)
            weights[wb_addr] <= filter_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ch_cnt <= '0;
        else if (accept) ch_cnt <= last_beat ? '0 : ch_cnt + AW'(1);
    end

    pe_mac_tree #(.DATA_W(DATA_W), .N_EL(N_EL), .SUM_W(SUM_W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ifmap  (ifmap),
        .weight (weights[ch_cnt]),
        .sum    (tree_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            last_pipe  <= '0;
            first_pipe <= '0;
            acc        <= '0;
        end else if (en) begin
            vld_pipe   <= {vld_pipe[STAGES-1:1], accept};
            last_pipe  <= {last_pipe[STAGES-1:1], last_beat};
            first_pipe <= {first_pipe[1], first_beat};
            if (vld_pipe[2])
                acc <= first_pipe[2] ? sum_ext : acc + sum_ext;
        end
    end

    always_comb begin
        if (acc > SAT_HI)      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        else if (acc < SAT_LO) sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else                   sat_val = acc[OUT_W-1:0];
    end

    // en low means a result is parked, so out_valid and psum_out simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            psum_out  <= '0;
        end else if (en) begin
            out_valid <= vld_pipe[STAGES] && last_pipe[STAGES];
            if (vld_pipe[STAGES] && last_pipe[STAGES])
                psum_out <= sat_val;
        end
    end
endmodule
